// File: rtl/add_float64_sigs.sv
// add_float64_sigs: same-sign binary64 magnitude add with sign zSign, ap_* block handshake.
// Five-stage fixed-latency datapath; rounding behaviour is locked by a 2-bit field of working_key.
module add_float64_sigs #(
    parameter int KEY_LSB = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        zSign,
    output logic [63:0] ap_return,
    input  logic [63:0] working_key
);
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_UNPACK = 6'b000010,
        S_ALIGN  = 6'b000100,
        S_ADD    = 6'b001000,
        S_ROUND  = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;
    localparam logic [63:0] QUIET = 64'h0008_0000_0000_0000;
    state_t state;
    logic [63:0] ra, rb, spec_val;
    logic rs, spec;
    logic [10:0] ea, eb;
    logic [55:0] sa, sb, big, small_s, sig;
    logic [11:0] e;
    logic [1:0] k;
    logic unused_bits;
    logic [10:0] ua, ub, d;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, u_spec;
    logic [63:0] u_val;
    logic a_big, lost;
    logic [55:0] sm, sh, al_small;
    logic [56:0] sum;
    logic [55:0] ad_sig;
    logic inc;
    logic [53:0] rnd;
    logic [11:0] re;
    logic [63:0] res;
    assign k = working_key[KEY_LSB+1:KEY_LSB];
    assign unused_bits = ^{working_key[63:KEY_LSB+2], working_key[KEY_LSB-1:0], rnd[52]};
    assign ap_done = state == S_DONE;
    assign ap_ready = ap_done;
    assign ap_idle = (state == S_IDLE) && !ap_start;
    assign ua = ra[62:52];
    assign ub = rb[62:52];
    assign a_nan = &ua & |ra[51:0];
    assign b_nan = &ub & |rb[51:0];
    assign a_inf = &ua & ~|ra[51:0];
    assign b_inf = &ub & ~|rb[51:0];
    assign a_zero = ~|ua;
    assign b_zero = ~|ub;
    assign u_spec = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign u_val = a_nan ? (ra | QUIET) :
                   b_nan ? (rb | QUIET) :
                   (a_inf | b_inf) ? {rs, 11'h7FF, 52'd0} :
                   (a_zero & b_zero) ? {rs, 63'd0} :
                   a_zero ? {rs, rb[62:0]} : {rs, ra[62:0]};
    // Alignment: a shift of 56 or more loses the whole significand into sticky.
    assign a_big = ea >= eb;
    assign d = a_big ? ea - eb : eb - ea;
    assign sm = a_big ? sb : sa;
    assign sh = (d >= 11'd56) ? '0 : sm >> d;
    assign lost = (d >= 11'd56) ? |sm : ((sh << d) != sm);
    assign al_small = {sh[55:1], sh[0] | (lost & ~k[0])};
    assign sum = {1'b0, big} + {1'b0, small_s};
    assign ad_sig = sum[56] ? {sum[56:2], sum[1] | (sum[0] & ~k[0])} : sum[55:0];
    assign inc = sig[2] & (sig[3] | sig[1] | sig[0]) & k[1];
    assign rnd = {1'b0, sig[55:3]} + {53'd0, inc};
    assign re = e + {11'd0, rnd[53]};
    assign res = spec ? spec_val :
                 (re >= 12'd2047) ? {rs, 11'h7FF, 52'd0} : {rs, re[10:0], rnd[51:0]};
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
            ra <= '0;
            rb <= '0;
            rs <= 1'b0;
            spec <= 1'b0;
            spec_val <= '0;
            ea <= '0;
            eb <= '0;
            sa <= '0;
            sb <= '0;
            big <= '0;
            small_s <= '0;
            sig <= '0;
            e <= '0;
            ap_return <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (ap_start) begin
                    ra <= a;
                    rb <= b;
                    rs <= zSign;
                    state <= S_UNPACK;
                end
                S_UNPACK: begin
                    spec <= u_spec;
                    spec_val <= u_val;
                    ea <= ua;
                    eb <= ub;
                    sa <= {1'b1, ra[51:0], 3'b000};
                    sb <= {1'b1, rb[51:0], 3'b000};
                    state <= S_ALIGN;
                end
                S_ALIGN: begin
                    e <= {1'b0, a_big ? ea : eb};
                    big <= a_big ? sa : sb;
                    small_s <= al_small;
                    state <= S_ADD;
                end
                S_ADD: begin
                    sig <= ad_sig;
                    e <= e + {11'd0, sum[56]};
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    ap_return <= res;
                    state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_float64_sigs.sv
// tb_add_float64_sigs: random and directed checks of add_float64_sigs against an exact-integer reference.
// The reference adds aligned significands exactly, then rounds from the true bit pattern.
module tb_add_float64_sigs;
    localparam int KL = 4;
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        z;
        logic [63:0] k;
        logic [63:0] r;
    } vec_t;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic ap_done, ap_idle, ap_ready;
    logic [63:0] a = '0, b = '0, working_key = '0;
    logic zsign = 1'b0;
    logic [63:0] ap_return;
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[11] = '{
        '{64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h20, 64'h4000000000000000},
        '{64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h20, 64'h3FF0000000000000},
        '{64'h3FF0000000000000, 64'h3CA0000000000001, 1'b0, 64'h20, 64'h3FF0000000000001},
        '{64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h20, 64'h7FF0000000000000},
        '{64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b1, 64'h20, 64'hFFF0000000000000},
        '{64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h20, 64'h7FF8000000000001},
        '{64'hFFF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h20, 64'h7FF0000000000000},
        '{64'h0000000000000001, 64'h3FF0000000000000, 1'b0, 64'h20, 64'h3FF0000000000000},
        '{64'h3FF0000000000000, 64'h3CA0000000000001, 1'b0, 64'h00, 64'h3FF0000000000000},
        '{64'h3FF0000000000000, 64'h3CA0000000000001, 1'b0, 64'h30, 64'h3FF0000000000000},
        '{64'h3FF0000000000000, 64'h3FF0000000000001, 1'b1, 64'h20, 64'hC000000000000000}
    };

    add_float64_sigs #(.KEY_LSB(KL)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .a(a), .b(b), .zSign(zsign),
        .ap_return(ap_return), .working_key(working_key)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic zs, input logic [63:0] key);
        logic [10:0] ex, ey, et;
        logic [52:0] mx, my, mt;
        logic [127:0] s;
        logic [53:0] m;
        logic k0, k1, g, rest;
        int d, p, sh, e;
        k0 = key[KL];
        k1 = key[KL+1];
        ex = x[62:52];
        ey = y[62:52];
        if (ex == 11'h7FF && x[51:0] != 0) return x | (64'd1 << 51);
        if (ey == 11'h7FF && y[51:0] != 0) return y | (64'd1 << 51);
        if (ex == 11'h7FF || ey == 11'h7FF) return {zs, 11'h7FF, 52'd0};
        if (ex == 0 && ey == 0) return {zs, 63'd0};
        if (ex == 0) return {zs, y[62:0]};
        if (ey == 0) return {zs, x[62:0]};
        mx = {1'b1, x[51:0]};
        my = {1'b1, y[51:0]};
        if (ex < ey) begin
            et = ex; ex = ey; ey = et;
            mt = mx; mx = my; my = mt;
        end
        d = int'(ex) - int'(ey);
        if (d > 60) return {zs, ex, mx[51:0]};
        s = (128'(mx) << d) + 128'(my);
        p = 0;
        for (int i = 0; i < 128; i++) if (s[i]) p = i;
        sh = p - 52;
        m = 54'(s >> sh);
        g = (sh >= 1) ? s[sh-1] : 1'b0;
        rest = 1'b0;
        // With the sticky lock set, only the two bits just below the guard bit can influence rounding.
        for (int i = 0; i < sh - 1; i++) if (s[i] && (!k0 || i >= sh - 3)) rest = 1'b1;
        if (g && (rest || m[0]) && k1) m = m + 54'd1;
        e = int'(ey) + sh;
        if (m[53]) begin
            e++;
            m = m >> 1;
        end
        if (e >= 2047) return {zs, 11'h7FF, 52'd0};
        return {zs, 11'(e), m[51:0]};
    endfunction

    function automatic logic [63:0] rnd_op(input int base);
        logic [63:0] f;
        int r, ev;
        f = {$urandom, $urandom};
        r = $urandom_range(0, 19);
        if (r < 2) ev = 0;
        else if (r == 2) ev = 2047;
        else if (r == 3) ev = $urandom_range(1, 2046);
        else begin
            ev = base + $urandom_range(0, 70) - 35;
            ev = ev < 1 ? 1 : (ev > 2046 ? 2046 : ev);
        end
        if (r == 0) f[51:0] = '0;
        if (r == 2 && f[0]) f[51:0] = '0;
        return {f[63], 11'(ev), f[51:0]};
    endfunction

    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tz,
                          input logic [63:0] tk, input logic lit_en, input logic [63:0] lit);
        int n;
        @(negedge ap_clk);
        a = ta; b = tb_v; zsign = tz; working_key = tk; ap_start = 1'b1;
        @(posedge ap_clk);
        exp_q.push_back(model(ta, tb_v, tz, tk));
        #1 ap_start = 1'b0;
        n = 0;
        do begin
            @(negedge ap_clk);
            n++;
            chk("idle_busy", 64'(ap_idle), 64'd0);
        end while (!ap_done && n < 20);
        chk("latency", 64'(n), 64'd5);
        if (lit_en) chk("literal", ap_return, lit);
    endtask

    initial begin
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n) begin
                chk("ready_eq_done", 64'(ap_ready), 64'(ap_done));
                if (ap_done) begin
                    if (exp_q.size() == 0) chk("spurious_done", 64'(ap_done), 64'd0);
                    else chk("result", ap_return, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n, m;
        logic [63:0] k;
        repeat (3) @(negedge ap_clk);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        chk("rst_return", ap_return, 64'd0);
        chk("rst_idle", 64'(ap_idle), 64'd1);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("idle_after_rst", 64'(ap_idle), 64'd1);

        foreach (vecs[i]) begin
            chk("model_pin", model(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].k), vecs[i].r);
            run_op(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].k, 1'b1, vecs[i].r);
        end

        for (int i = 0; i < 200; i++) begin
            int base;
            base = $urandom_range(40, 2040);
            k = {$urandom, $urandom};
            run_op(rnd_op(base), rnd_op(base), 1'($urandom), k, 1'b0, 64'd0);
        end

        // Start held high: second op must be accepted straight after S_DONE.
        @(negedge ap_clk);
        a = 64'h3FF0000000000000; b = 64'h4000000000000000; zsign = 1'b0;
        working_key = 64'h20; ap_start = 1'b1;
        @(posedge ap_clk);
        exp_q.push_back(64'h4008000000000000);
        exp_q.push_back(64'hC010000000000000);
        #1 a = 64'h4000000000000000; b = 64'h4000000000000000; zsign = 1'b1;
        n = 0;
        do begin @(negedge ap_clk); n++; end while (!ap_done && n < 20);
        chk("b2b_first_latency", 64'(n), 64'd5);
        m = 0;
        do begin
            @(negedge ap_clk);
            m++;
            if (m == 1) chk("b2b_idle_low", 64'(ap_idle), 64'd0);
        end while (!ap_done && m < 20);
        ap_start = 1'b0;
        chk("b2b_interval", 64'(m), 64'd6);

        // Asynchronous reset in the middle of an operation.
        @(negedge ap_clk);
        a = 64'h3FF0000000000000; b = 64'h3FF0000000000000; working_key = 64'h20; ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("abort_return", ap_return, 64'd0);
        chk("abort_done", 64'(ap_done), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge ap_clk);
            chk("abort_no_done", 64'(ap_done), 64'd0);
            chk("abort_idle", 64'(ap_idle), 64'd1);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
